// File: rtl/alien_pool_ctrl.sv
// alien_pool_ctrl
//   Manages a fixed pool of alien slots for one level: periodic spawning
//   against a per-level quota, a priority drawing mux, kill handling with a
//   dying hold-off, player-death recall and level-clear detection.
//
// Ports
//   clk           system clock, all state on rising edge
//   resetN        asynchronous active-low reset
//   startOfFrame  one-cycle pulse at each frame start
//   slot_dr       per-slot drawing request for the current pixel
//   slot_RGB      per-slot colour, slot i at [12i+11:12i]
//   alien_died    current drawn alien pixel was hit (one-cycle pulse)
//   player_died   player lost (one-cycle pulse)
//   alive         registered per-slot enable (slot is ALIVE)
//   alien_dr      combined drawing request (combinational)
//   alien_RGB     colour of the winning slot, 12'h000 when none (combinational)
//   spawn_pulse   one-cycle pulse when a slot is spawned
//   spawn_idx     spawned slot index, valid with spawn_pulse
//   kill_count    kills in the current level, saturates at TOTAL_ALIENS
//   level_clear   high once kill_count reaches TOTAL_ALIENS
//
// Slot states
//   state    | meaning
//   S_IDLE   | slot free, may be spawned
//   S_ALIVE  | alien on screen, draws and can be killed
//   S_DYING  | killed, blocked for DYING_FRAMES frame starts

module alien_pool_ctrl #(
   parameter int NUM_ALIENS   = 4,
   parameter int SPAWN_PERIOD = 60,
   parameter int TOTAL_ALIENS = 8,
   parameter int DYING_FRAMES = 8,
   localparam int IDXW = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     startOfFrame,
   input  logic [NUM_ALIENS-1:0]    slot_dr,
   input  logic [12*NUM_ALIENS-1:0] slot_RGB,
   input  logic                     alien_died,
   input  logic                     player_died,
   output logic [NUM_ALIENS-1:0]    alive,
   output logic                     alien_dr,
   output logic [11:0]              alien_RGB,
   output logic                     spawn_pulse,
   output logic [IDXW-1:0]          spawn_idx,
   output logic [7:0]               kill_count,
   output logic                     level_clear
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALIVE = 2'd1,
      S_DYING = 2'd2
   } slot_state_t;

   localparam logic [9:0] TIMER_LAST = 10'(SPAWN_PERIOD - 1);
   localparam logic [7:0] DYING_LAST = 8'(DYING_FRAMES - 1);
   localparam logic [7:0] QUOTA      = 8'(TOTAL_ALIENS);

   slot_state_t            state_q [NUM_ALIENS];
   slot_state_t            state_d [NUM_ALIENS];
   logic [7:0]             dcnt_q  [NUM_ALIENS];
   logic [7:0]             dcnt_d  [NUM_ALIENS];
   logic [NUM_ALIENS-1:0]  alive_q, alive_d;
   logic [9:0]             timer_q, timer_d;
   logic [7:0]             spawned_q, spawned_d;
   logic [7:0]             kill_count_q, kill_count_d;
   logic                   level_clear_q, level_clear_d;
   logic                   spawn_pulse_q, spawn_pulse_d;
   logic [IDXW-1:0]        spawn_idx_q, spawn_idx_d;

   logic                   win_found;
   logic [IDXW-1:0]        win_idx;
   logic [11:0]            win_rgb;
   logic                   idle_found;
   logic [IDXW-1:0]        idle_idx;
   logic [7:0]             alive_cnt;

   // Priority mux: scan high to low so the lowest matching index wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_rgb   = 12'h000;
      for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
         if (slot_dr[i] && alive_q[i]) begin
            win_found = 1'b1;
            win_idx   = IDXW'(i);
            win_rgb   = slot_RGB[12*i +: 12];
         end
      end
   end

   assign alien_dr  = win_found;
   assign alien_RGB = win_rgb;

   always_comb begin
      state_d       = state_q;
      dcnt_d        = dcnt_q;
      timer_d       = timer_q;
      spawned_d     = spawned_q;
      kill_count_d  = kill_count_q;
      spawn_pulse_d = 1'b0;
      spawn_idx_d   = '0;
      idle_found    = 1'b0;
      idle_idx      = '0;
      alive_cnt     = '0;
      alive_d       = '0;

      // Spawn eligibility uses the current state, so a slot killed or
      // finishing its dying period this cycle cannot be spawned this cycle.
      for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
         if (state_q[i] == S_IDLE) begin
            idle_found = 1'b1;
            idle_idx   = IDXW'(i);
         end
         if (state_q[i] == S_ALIVE) begin
            alive_cnt = alive_cnt + 8'd1;
         end
      end

      if (player_died) begin
         for (int i = 0; i < NUM_ALIENS; i++) begin
            state_d[i] = S_IDLE;
            dcnt_d[i]  = '0;
         end
         timer_d   = '0;
         // Aliens still on screen go back to the quota.
         spawned_d = spawned_q - alive_cnt;
      end else begin
         if (startOfFrame) begin
            for (int i = 0; i < NUM_ALIENS; i++) begin
               if (state_q[i] == S_DYING) begin
                  if (dcnt_q[i] == DYING_LAST) begin
                     state_d[i] = S_IDLE;
                     dcnt_d[i]  = '0;
                  end else begin
                     dcnt_d[i] = dcnt_q[i] + 8'd1;
                  end
               end
            end
         end

         if (alien_died && win_found) begin
            state_d[win_idx] = S_DYING;
            dcnt_d[win_idx]  = '0;
            if (kill_count_q < QUOTA) begin
               kill_count_d = kill_count_q + 8'd1;
            end
         end

         if (startOfFrame) begin
            if (timer_q == TIMER_LAST) begin
               // Otherwise hold at the last count so the next free frame spawns.
               if (idle_found && (spawned_q < QUOTA) && !level_clear_q) begin
                  state_d[idle_idx] = S_ALIVE;
                  spawned_d         = spawned_q + 8'd1;
                  timer_d           = '0;
                  spawn_pulse_d     = 1'b1;
                  spawn_idx_d       = idle_idx;
               end
            end else begin
               timer_d = timer_q + 10'd1;
            end
         end
      end

      level_clear_d = level_clear_q | (kill_count_d == QUOTA);

      for (int i = 0; i < NUM_ALIENS; i++) begin
         alive_d[i] = (state_d[i] == S_ALIVE);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_ALIENS; i++) begin
            state_q[i] <= S_IDLE;
            dcnt_q[i]  <= '0;
         end
         alive_q       <= '0;
         timer_q       <= '0;
         spawned_q     <= '0;
         kill_count_q  <= '0;
         level_clear_q <= 1'b0;
         spawn_pulse_q <= 1'b0;
         spawn_idx_q   <= '0;
      end else begin
         state_q       <= state_d;
         dcnt_q        <= dcnt_d;
         alive_q       <= alive_d;
         timer_q       <= timer_d;
         spawned_q     <= spawned_d;
         kill_count_q  <= kill_count_d;
         level_clear_q <= level_clear_d;
         spawn_pulse_q <= spawn_pulse_d;
         spawn_idx_q   <= spawn_idx_d;
      end
   end

   assign alive       = alive_q;
   assign spawn_pulse = spawn_pulse_q;
   assign spawn_idx   = spawn_idx_q;
   assign kill_count  = kill_count_q;
   assign level_clear = level_clear_q;

endmodule

// File: tb/tb_alien_pool_ctrl.sv
// Testbench for alien_pool_ctrl: directed scenarios plus a randomized run,
// all cycles checked against a slot-level behavioural model.

module tb_alien_pool_ctrl;

   localparam int NA = 4;
   localparam int SP = 3;
   localparam int TA = 8;
   localparam int DF = 2;
   localparam int IW = 2;
   localparam int FRAME_LEN = 10;

   logic            clk = 1'b0;
   logic            resetN;
   logic            startOfFrame;
   logic [NA-1:0]   slot_dr;
   logic [12*NA-1:0] slot_RGB;
   logic            alien_died;
   logic            player_died;
   logic [NA-1:0]   alive;
   logic            alien_dr;
   logic [11:0]     alien_RGB;
   logic            spawn_pulse;
   logic [IW-1:0]   spawn_idx;
   logic [7:0]      kill_count;
   logic            level_clear;

   always #5 clk = ~clk;

   alien_pool_ctrl #(
      .NUM_ALIENS(NA), .SPAWN_PERIOD(SP), .TOTAL_ALIENS(TA), .DYING_FRAMES(DF)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .slot_dr(slot_dr), .slot_RGB(slot_RGB),
      .alien_died(alien_died), .player_died(player_died),
      .alive(alive), .alien_dr(alien_dr), .alien_RGB(alien_RGB),
      .spawn_pulse(spawn_pulse), .spawn_idx(spawn_idx),
      .kill_count(kill_count), .level_clear(level_clear)
   );

   int checks = 0;
   int errors = 0;

   // Model: 0 = idle, 1 = alive, 2 = dying
   int m_st [NA];
   int m_dc [NA];
   int m_timer, m_spawned, m_kills, m_idx;
   bit m_lvl, m_pulse;

   int frame_no;
   int log_frame[$];
   int log_idx[$];

   task automatic model_reset();
      for (int i = 0; i < NA; i++) begin
         m_st[i] = 0;
         m_dc[i] = 0;
      end
      m_timer = 0; m_spawned = 0; m_kills = 0; m_idx = 0;
      m_lvl = 0; m_pulse = 0;
   endtask

   function automatic int m_winner();
      for (int i = 0; i < NA; i++)
         if (slot_dr[i] && m_st[i] == 1) return i;
      return -1;
   endfunction

   task automatic model_edge();
      int st [NA];
      int dc [NA];
      int w, first_idle, n_alive;
      st = m_st;
      dc = m_dc;
      m_pulse = 0;
      if (player_died) begin
         n_alive = 0;
         for (int i = 0; i < NA; i++) begin
            if (m_st[i] == 1) n_alive++;
            st[i] = 0;
            dc[i] = 0;
         end
         m_spawned -= n_alive;
         m_timer = 0;
      end else begin
         w = m_winner();
         if (startOfFrame) begin
            for (int i = 0; i < NA; i++) begin
               if (m_st[i] == 2) begin
                  dc[i]++;
                  if (dc[i] == DF) begin
                     st[i] = 0;
                     dc[i] = 0;
                  end
               end
            end
         end
         if (alien_died && w >= 0) begin
            st[w] = 2;
            dc[w] = 0;
            if (m_kills < TA) m_kills++;
         end
         if (startOfFrame) begin
            if (m_timer == SP - 1) begin
               first_idle = -1;
               for (int i = NA - 1; i >= 0; i--)
                  if (m_st[i] == 0) first_idle = i;
               if (m_spawned < TA && !m_lvl && first_idle >= 0) begin
                  st[first_idle] = 1;
                  m_spawned++;
                  m_timer = 0;
                  m_pulse = 1;
                  m_idx = first_idle;
               end
            end else begin
               m_timer++;
            end
         end
         if (m_kills == TA) m_lvl = 1;
      end
      m_st = st;
      m_dc = dc;
   endtask

   // Entered at posedge+1 with inputs already driven; leaves at posedge+1.
   task automatic cycle();
      int w;
      logic [11:0] exp_rgb;
      logic [NA-1:0] exp_alive;
      bit exp_dr;
      #1;
      w = m_winner();
      exp_dr = (w >= 0);
      exp_rgb = exp_dr ? slot_RGB[w*12 +: 12] : 12'h000;
      checks++;
      if (alien_dr !== exp_dr || alien_RGB !== exp_rgb) begin
         errors++;
         $display("FAIL draw t=%0t: got dr=%b rgb=%h, want dr=%b rgb=%h",
                  $time, alien_dr, alien_RGB, exp_dr, exp_rgb);
      end
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < NA; i++) exp_alive[i] = (m_st[i] == 1);
      checks++;
      if (alive !== exp_alive || spawn_pulse !== m_pulse ||
          (m_pulse && spawn_idx !== IW'(m_idx)) ||
          kill_count !== 8'(m_kills) || level_clear !== m_lvl) begin
         errors++;
         $display("FAIL state t=%0t: got alive=%b sp=%b idx=%0d kc=%0d lc=%b, want alive=%b sp=%b idx=%0d kc=%0d lc=%b",
                  $time, alive, spawn_pulse, spawn_idx, kill_count, level_clear,
                  exp_alive, m_pulse, m_idx, m_kills, m_lvl);
      end
      if (spawn_pulse === 1'b1) begin
         log_frame.push_back(frame_no);
         log_idx.push_back(int'(spawn_idx));
      end
   endtask

   task automatic step(bit sof, bit ad, bit pd);
      startOfFrame = sof;
      alien_died   = ad;
      player_died  = pd;
      cycle();
      startOfFrame = 1'b0;
      alien_died   = 1'b0;
      player_died  = 1'b0;
   endtask

   task automatic run_frames(int n);
      for (int f = 0; f < n; f++) begin
         frame_no++;
         step(1, 0, 0);
         repeat (FRAME_LEN - 1) step(0, 0, 0);
      end
   endtask

   task automatic clear_log();
      frame_no = 0;
      log_frame.delete();
      log_idx.delete();
   endtask

   task automatic check_single_spawn(string name, int want_frame, int want_idx);
      checks++;
      if (log_frame.size() != 1) begin
         errors++;
         $display("FAIL %s: got %0d spawns, want 1", name, log_frame.size());
      end else if (log_frame[0] != want_frame || log_idx[0] != want_idx) begin
         errors++;
         $display("FAIL %s: got frame %0d idx %0d, want frame %0d idx %0d",
                  name, log_frame[0], log_idx[0], want_frame, want_idx);
      end
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      startOfFrame = 1'b0; alien_died = 1'b0; player_died = 1'b0;
      slot_dr = '1;
      slot_RGB = 48'hABC_DEF_123_456;
      #3;
      checks++;
      if (alive !== 4'b0 || spawn_pulse !== 1'b0 || spawn_idx !== 2'd0 ||
          kill_count !== 8'd0 || level_clear !== 1'b0 || alien_dr !== 1'b0 ||
          alien_RGB !== 12'h000) begin
         errors++;
         $display("FAIL reset_values: alive=%b sp=%b idx=%0d kc=%0d lc=%b dr=%b rgb=%h, want all zero",
                  alive, spawn_pulse, spawn_idx, kill_count, level_clear, alien_dr, alien_RGB);
      end
      @(posedge clk);
      #1;
      resetN = 1'b1;
      model_reset();
      step(0, 0, 0);
   endtask

   task automatic test_spawn();
      slot_dr = '0;
      clear_log();
      run_frames(14);
      checks++;
      if (log_frame.size() != 4) begin
         errors++;
         $display("FAIL spawn_count: got %0d, want 4", log_frame.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (log_frame[k] != 3 * (k + 1) || log_idx[k] != k) begin
               errors++;
               $display("FAIL spawn_seq[%0d]: got frame %0d idx %0d, want frame %0d idx %0d",
                        k, log_frame[k], log_idx[k], 3 * (k + 1), k);
            end
         end
      end
      checks++;
      if (alive !== 4'b1111) begin
         errors++;
         $display("FAIL all_alive: got %b, want 1111", alive);
      end
   endtask

   task automatic test_draw_kill();
      slot_RGB = {12'h00F, 12'h0F0, 12'hF00, 12'h111};
      slot_dr = 4'b0110;
      #1;
      checks++;
      if (alien_dr !== 1'b1 || alien_RGB !== 12'hF00) begin
         errors++;
         $display("FAIL draw_priority: got dr=%b rgb=%h, want dr=1 rgb=f00", alien_dr, alien_RGB);
      end
      step(0, 1, 0);
      checks++;
      if (alive !== 4'b1101 || kill_count !== 8'd1) begin
         errors++;
         $display("FAIL kill: got alive=%b kc=%0d, want alive=1101 kc=1", alive, kill_count);
      end
      slot_dr = 4'b0010;
      step(0, 1, 0);
      checks++;
      if (alive !== 4'b1101 || kill_count !== 8'd1) begin
         errors++;
         $display("FAIL kill_dying_ignored: got alive=%b kc=%0d, want alive=1101 kc=1", alive, kill_count);
      end
   endtask

   task automatic test_dying_respawn();
      slot_dr = '0;
      clear_log();
      run_frames(4);
      check_single_spawn("dying_respawn", 3, 1);
   endtask

   task automatic test_player_died();
      slot_dr = 4'b0001;
      step(0, 1, 0);
      slot_dr = 4'b0010;
      step(0, 1, 1);
      checks++;
      if (alive !== 4'b0000 || kill_count !== 8'd2 || spawn_pulse !== 1'b0) begin
         errors++;
         $display("FAIL player_died: got alive=%b kc=%0d sp=%b, want alive=0000 kc=2 sp=0",
                  alive, kill_count, spawn_pulse);
      end
      slot_dr = '0;
      clear_log();
      run_frames(4);
      check_single_spawn("timer_cleared", 3, 0);
   endtask

   task automatic test_level_clear();
      int f;
      slot_dr = '1;
      f = 0;
      while (level_clear !== 1'b1 && f < 100) begin
         frame_no++;
         step(1, 0, 0);
         step(0, 1, 0);
         repeat (FRAME_LEN - 2) step(0, 0, 0);
         f++;
      end
      checks++;
      if (level_clear !== 1'b1 || kill_count !== 8'(TA)) begin
         errors++;
         $display("FAIL level_clear: got lc=%b kc=%0d after %0d frames, want lc=1 kc=%0d",
                  level_clear, kill_count, f, TA);
      end
      clear_log();
      run_frames(8);
      checks++;
      if (log_frame.size() != 0) begin
         errors++;
         $display("FAIL no_spawn_after_clear: got %0d spawns, want 0", log_frame.size());
      end
   endtask

   task automatic test_reset_mid();
      slot_dr = '1;
      step(1, 0, 0);
      #2;
      resetN = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (alive !== 4'b0 || spawn_pulse !== 1'b0 || spawn_idx !== 2'd0 ||
             kill_count !== 8'd0 || level_clear !== 1'b0 || alien_dr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid[%0d]: alive=%b sp=%b idx=%0d kc=%0d lc=%b dr=%b, want all zero",
                     k, alive, spawn_pulse, spawn_idx, kill_count, level_clear, alien_dr);
         end
         @(posedge clk);
         #1;
      end
      resetN = 1'b1;
      model_reset();
      slot_dr = '0;
      clear_log();
      run_frames(4);
      check_single_spawn("spawn_after_reset", 3, 0);
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         slot_dr  = NA'($urandom);
         slot_RGB = 48'({$urandom, $urandom});
         step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 99) == 0);
      end
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_draw_kill();
      test_dying_respawn();
      test_player_died();
      test_level_clear();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
